// File: rtl/regfile_wb_sched.sv
// Write-back scheduler for the single-write-port register file: round-robin ALU/LSU
// arbitration onto the write port plus a per-register busy scoreboard for RAW/WAW stalls.
module regfile_wb_sched #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  input  logic            issue_re1,
  input  logic [AW-1:0]   issue_rs1,
  input  logic            issue_re2,
  input  logic [AW-1:0]   issue_rs2,
  output logic            issue_stall,
  input  logic            alu_valid,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  output logic            alu_ready,
  input  logic            lsu_valid,
  input  logic [AW-1:0]   lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            lsu_ready,
  output logic            we,
  output logic [AW-1:0]   waddr,
  output logic [XLEN-1:0] wdata
);

  logic [NREG-1:1] busy_r;
  logic            last_grant_r;
  logic [NREG-1:0] busy_full_s;
  logic            grant_alu_s;
  logic            grant_lsu_s;
  logic            hazard_s;
  logic            accept_s;

  // Hazard on r unless a same-cycle write to r is being forwarded by the register file.
  function automatic logic hz(input logic [NREG-1:0] bsy, input logic [AW-1:0] r,
                              input logic wen, input logic [AW-1:0] wa);
    hz = (r != {AW{1'b0}}) & bsy[r] & ~(wen & (wa == r));
  endfunction

  assign busy_full_s = {busy_r, 1'b0};
  assign grant_alu_s = alu_valid & (~lsu_valid | last_grant_r);
  assign grant_lsu_s = lsu_valid & (~alu_valid | ~last_grant_r);

  // Grant and write-port drive.
  always_comb begin
    alu_ready = 1'b0;
    lsu_ready = 1'b0;
    we        = 1'b0;
    waddr     = {AW{1'b0}};
    wdata     = {XLEN{1'b0}};
    if (rst || flush) begin
      alu_ready = 1'b0;
      lsu_ready = 1'b0;
    end else if (grant_alu_s) begin
      alu_ready = 1'b1;
      if (alu_rd != {AW{1'b0}}) begin
        we    = 1'b1;
        waddr = alu_rd;
        wdata = alu_data;
      end else begin
        we = 1'b0;
      end
    end else if (grant_lsu_s) begin
      lsu_ready = 1'b1;
      if (lsu_rd != {AW{1'b0}}) begin
        we    = 1'b1;
        waddr = lsu_rd;
        wdata = lsu_data;
      end else begin
        we = 1'b0;
      end
    end else begin
      we = 1'b0;
    end
  end

  // Issue hazard detection and accept.
  always_comb begin
    hazard_s    = (issue_re1 & hz(busy_full_s, issue_rs1, we, waddr)) |
                  (issue_re2 & hz(busy_full_s, issue_rs2, we, waddr)) |
                  hz(busy_full_s, issue_rd, we, waddr);
    issue_stall = 1'b0;
    accept_s    = 1'b0;
    if (rst) begin
      issue_stall = 1'b0;
    end else if (flush) begin
      issue_stall = issue_valid;
    end else begin
      issue_stall = issue_valid & hazard_s;
      accept_s    = issue_valid & ~hazard_s;
    end
  end

  // Scoreboard: clear on write-back, set on accepted issue (set wins).
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      busy_r <= {(NREG-1){1'b0}};
    end else begin
      for (int i = 1; i < NREG; i++) begin
        busy_r[i] <= (busy_r[i] & ~(we & (waddr == AW'(i)))) |
                     (accept_s & (issue_rd == AW'(i)));
      end
    end
  end

  // Round-robin pointer follows the last completed transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_r <= 1'b1;
    end else if (alu_ready) begin
      last_grant_r <= 1'b0;
    end else if (lsu_ready) begin
      last_grant_r <= 1'b1;
    end else begin
      last_grant_r <= last_grant_r;
    end
  end

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched: arbitration order, write port, scoreboard stalls,
// flush and reset behaviour, with hand-computed expected values.
module tb_regfile_wb_sched;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic            clk;
  logic            rst;
  logic            flush;
  logic            issue_valid;
  logic [AW-1:0]   issue_rd;
  logic            issue_re1;
  logic [AW-1:0]   issue_rs1;
  logic            issue_re2;
  logic [AW-1:0]   issue_rs2;
  logic            issue_stall;
  logic            alu_valid;
  logic [AW-1:0]   alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_ready;
  logic            lsu_valid;
  logic [AW-1:0]   lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            lsu_ready;
  logic            we;
  logic [AW-1:0]   waddr;
  logic [XLEN-1:0] wdata;

  int n_checks;
  int n_fail;

  regfile_wb_sched #(.XLEN(XLEN), .NREG(32), .AW(AW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_re1(issue_re1), .issue_rs1(issue_rs1),
    .issue_re2(issue_re2), .issue_rs2(issue_rs2),
    .issue_stall(issue_stall),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .we(we), .waddr(waddr), .wdata(wdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    flush = 1'b0;
    issue_valid = 1'b0; issue_rd = 5'd0;
    issue_re1 = 1'b0; issue_rs1 = 5'd0; issue_re2 = 1'b0; issue_rs2 = 5'd0;
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
    lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_data = 32'd0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [AW-1:0] rd, input logic re1, input logic [AW-1:0] rs1,
                       input logic re2, input logic [AW-1:0] rs2);
    issue_valid = 1'b1; issue_rd = rd;
    issue_re1 = re1; issue_rs1 = rs1; issue_re2 = re2; issue_rs2 = rs2;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    idle();
    // Reset active with pending ALU result: nothing must be written or acknowledged.
    rst = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    issue(5'd1, 1'b1, 5'd2, 1'b0, 5'd0);
    #2;
    check("rst_we", we, 1'b0);
    check("rst_waddr", waddr, 5'd0);
    check("rst_wdata", wdata, 32'd0);
    check("rst_alu_ready", alu_ready, 1'b0);
    check("rst_stall", issue_stall, 1'b0);
    step();
    rst = 1'b0;
    issue_valid = 1'b0;
    #1;
    // T1: first ALU result passes straight through.
    check("t1_we", we, 1'b1);
    check("t1_waddr", waddr, 5'd5);
    check("t1_wdata", wdata, 32'hDEADBEEF);
    check("t1_alu_ready", alu_ready, 1'b1);
    check("t1_lsu_ready", lsu_ready, 1'b0);
    step();

    // T2: both valid after reset -> ALU, LSU, ALU.
    do_reset();
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h44;
    #1;
    check("t2_c0_alu_ready", alu_ready, 1'b1);
    check("t2_c0_lsu_ready", lsu_ready, 1'b0);
    check("t2_c0_waddr", waddr, 5'd3);
    step();
    check("t2_c1_alu_ready", alu_ready, 1'b0);
    check("t2_c1_lsu_ready", lsu_ready, 1'b1);
    check("t2_c1_waddr", waddr, 5'd4);
    check("t2_c1_wdata", wdata, 32'h44);
    step();
    check("t2_c2_alu_ready", alu_ready, 1'b1);
    check("t2_c2_waddr", waddr, 5'd3);
    step();
    idle();

    // T3: RAW on x7 until the LSU writes it back.
    issue(5'd7, 1'b0, 5'd0, 1'b0, 5'd0);
    #1;
    check("t3_issue_rd7", issue_stall, 1'b0);
    step();
    issue(5'd0, 1'b1, 5'd7, 1'b0, 5'd0);
    #1;
    check("t3_raw_c0", issue_stall, 1'b1);
    step();
    check("t3_raw_c1", issue_stall, 1'b1);
    step();
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h77;
    #1;
    check("t3_fwd_stall", issue_stall, 1'b0);
    check("t3_fwd_we", we, 1'b1);
    check("t3_fwd_waddr", waddr, 5'd7);
    check("t3_lsu_ready", lsu_ready, 1'b1);
    step();
    lsu_valid = 1'b0;
    #1;
    check("t3_cleared", issue_stall, 1'b0);
    step();
    idle();

    // WAW on x8, then T5: flush clears x8 and x9; last_grant (LSU) must hold.
    issue(5'd8, 1'b0, 5'd0, 1'b0, 5'd0);
    step();
    #1;
    check("waw_rd8", issue_stall, 1'b1);
    issue(5'd9, 1'b0, 5'd0, 1'b0, 5'd0);
    #1;
    check("t5_issue_rd9", issue_stall, 1'b0);
    step();
    flush = 1'b1;
    issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h22;
    lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_data = 32'hAA;
    #1;
    check("t5_flush_alu_ready", alu_ready, 1'b0);
    check("t5_flush_lsu_ready", lsu_ready, 1'b0);
    check("t5_flush_we", we, 1'b0);
    check("t5_flush_stall", issue_stall, 1'b1);
    step();
    flush = 1'b0;
    issue(5'd0, 1'b1, 5'd9, 1'b1, 5'd8);
    #1;
    check("t5_post_stall", issue_stall, 1'b0);
    check("t5_post_alu_ready", alu_ready, 1'b1);
    check("t5_post_waddr", waddr, 5'd2);
    step();
    idle();

    // T4: rd=0 transfer completes without writing; x0 never stalls.
    issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234;
    #1;
    check("t4_we", we, 1'b0);
    check("t4_waddr", waddr, 5'd0);
    check("t4_wdata", wdata, 32'd0);
    check("t4_alu_ready", alu_ready, 1'b1);
    step();
    alu_valid = 1'b0;
    issue(5'd0, 1'b1, 5'd0, 1'b1, 5'd0);
    #1;
    check("t4_x0_stall", issue_stall, 1'b0);
    step();
    idle();

    // T6: write-back of x6 and new issue to x6 in the same cycle; set wins.
    issue(5'd6, 1'b0, 5'd0, 1'b0, 5'd0);
    step();
    alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'h66;
    #1;
    check("t6_stall", issue_stall, 1'b0);
    check("t6_we", we, 1'b1);
    check("t6_waddr", waddr, 5'd6);
    check("t6_wdata", wdata, 32'h66);
    step();
    idle();
    issue(5'd0, 1'b1, 5'd6, 1'b0, 5'd0);
    #1;
    check("t6_busy_kept", issue_stall, 1'b1);
    step();

    // Reset clears the scoreboard.
    do_reset();
    issue(5'd0, 1'b1, 5'd6, 1'b0, 5'd0);
    #1;
    check("rst_clears_busy", issue_stall, 1'b0);
    step();
    idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
